sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Round-robin arbiter that shares one byte-wide SDRAM controller (sdram_controller_w9825g6kh) among NUM_PORTS requesters. Requesters see the same wr/rd/rdy/val handshake the controller presents. The arbiter sequences one command at a time into the controller and routes each read result back to the port that issued it. It sits between client logic (CPU bus, DMA, video fetch) and the controller, in the controller's clock domain.

## Interface
- NUM_PORTS, 2, number of requester ports (2..4)
- ADDR_DEPTH, 24, byte address width; matches the controller's addr_in
- clk  in  1  system clock; also clocks the controller
- rst  in  1  synchronous, active-high reset
- req_wr  in  NUM_PORTS  per-port write request; held until req_rdy
- req_rd  in  NUM_PORTS  per-port read request; held until req_rdy
- req_addr  in  NUM_PORTS*ADDR_DEPTH  per-port byte address; port i at [i*ADDR_DEPTH +: ADDR_DEPTH]
- req_data_wr  in  NUM_PORTS*8  per-port write byte; port i at [i*8 +: 8]
- req_rdy  out  NUM_PORTS  one-cycle accept pulse to the granted port
- req_val  out  NUM_PORTS  one-cycle read-data-valid pulse to the issuing port
- req_data_rd  out  8  read byte, shared by all ports; qualified by req_val
- ctl_wr, ctl_rd  out  1 each  controller command strobes
- ctl_addr  out  ADDR_DEPTH  controller address
- ctl_data_wr  out  8  controller write byte
- ctl_rdy  in  1  controller accepts the command while this is high with ctl_wr or ctl_rd
- ctl_val  in  1  controller read-data valid
- ctl_data_rd  in  8  controller read byte

## Operation
- FSM states are IDLE, ISSUE and WAIT_RD. Reset enters IDLE, sets the round-robin pointer last to NUM_PORTS-1 (port 0 has first priority), and drives every output to 0.
- IDLE:
  - A port is requesting when req_wr[i] | req_rd[i].
  - The winner is the first requesting port after last, scanning upward and wrapping modulo NUM_PORTS.
  - The winner's addr, data and op are captured into registers. When a port has both wr and rd high, wr wins.
  - Grant index g and last are set to the winner, and the FSM enters ISSUE.
  - With no requester, the FSM stays in IDLE.
- ISSUE:
  - ctl_wr or ctl_rd (the captured op) is held high, with ctl_addr and ctl_data_wr taken from the captured registers.
  - On a cycle where ctl_rdy is sampled high, the arbiter drops ctl_wr/ctl_rd and pulses req_rdy[g] on the next cycle.
  - It then goes to IDLE after a write, or to WAIT_RD after a read.
- WAIT_RD:
  - No new grant is made; at most one read is outstanding.
  - On ctl_val, req_data_rd is registered from ctl_data_rd, req_val[g] pulses for one cycle, and the FSM returns to IDLE.
  - ctl_val arriving in any state other than WAIT_RD is ignored.
- Requester inputs are sampled only in IDLE. A port that drops its request after grant still has the captured command completed and still receives req_rdy.
- req_data_rd holds its last value between req_val pulses.
- Reset mid-operation (ISSUE or WAIT_RD) abandons the command. Every output goes to 0 the cycle after rst is sampled, and no req_rdy or req_val is issued for the abandoned command.

## Timing
- Grant latency: a request sampled in IDLE at edge T drives ctl_wr/ctl_rd high from T to the accept edge.
- With ctl_rdy already high, the controller accepts at T+1 and req_rdy[g] is high during T+1..T+2.
- ctl_wr/ctl_rd are low for at least one cycle between consecutive commands, because of the IDLE bubble.
- Read data latency: req_val[g] follows ctl_val by exactly 1 cycle.
- req_rdy and req_val are never high on more than one port bit in the same cycle.
- A port requesting continuously is granted within NUM_PORTS commands of any other continuously requesting port (no starvation).

## Test plan
- Reset then single write: port0 writes 0xA5 to 0x123456 → ctl_wr=1, ctl_addr=0x123456, ctl_data_wr=0xA5 until ctl_rdy; req_rdy=2'b01 for one cycle; no req_val.
- Write/read routing: port1 writes 0x3C to 0x000010, then reads 0x000010 through the controller model → req_val=2'b10 with req_data_rd=0x3C; req_val[0] stays 0.
- Round-robin: both ports hold reads continuously for 6 commands → grant order 0,1,0,1,0,1; each req_val goes to the port whose read it completes.
- Same-port wr+rd: port0 raises wr=1 and rd=1 together with data 0x77 → ctl_wr issued first; only after port0 drops wr is ctl_rd issued.
- Outstanding read blocks grants: port0 reads with ctl_val delayed 10 cycles while port1 requests a write → ctl_wr stays 0 until the cycle after port0's req_val.
- Reset mid-read: assert rst while in WAIT_RD → all outputs are 0 on the next cycle; a later ctl_val produces no req_val; after reset, port0 wins a simultaneous 2-port request.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide SDRAM controller among NUM_PORTS requesters.
// One command is in flight at a time; a read holds off new grants until its data returns,
// so the returning byte can be routed to the port that issued it.
module sdram_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_DEPTH = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_wr,
    input  logic [NUM_PORTS-1:0]            req_rd,
    input  logic [NUM_PORTS*ADDR_DEPTH-1:0] req_addr,
    input  logic [NUM_PORTS*8-1:0]          req_data_wr,
    output logic [NUM_PORTS-1:0]            req_rdy,
    output logic [NUM_PORTS-1:0]            req_val,
    output logic [7:0]                      req_data_rd,
    output logic                            ctl_wr,
    output logic                            ctl_rd,
    output logic [ADDR_DEPTH-1:0]           ctl_addr,
    output logic [7:0]                      ctl_data_wr,
    input  logic                            ctl_rdy,
    input  logic                            ctl_val,
    input  logic [7:0]                      ctl_data_rd
);

    localparam int NP = int'(NUM_PORTS);
    localparam int AW = int'(ADDR_DEPTH);
    localparam int PW = (NUM_PORTS > 2) ? 2 : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          last_q, last_d;
    logic [PW-1:0]          grant_q, grant_d;
    logic                   ctl_wr_q, ctl_wr_d;
    logic                   ctl_rd_q, ctl_rd_d;
    logic [ADDR_DEPTH-1:0]  ctl_addr_q, ctl_addr_d;
    logic [7:0]             ctl_data_wr_q, ctl_data_wr_d;
    logic [NUM_PORTS-1:0]   req_rdy_q, req_rdy_d;
    logic [NUM_PORTS-1:0]   req_val_q, req_val_d;
    logic [7:0]             req_data_rd_q, req_data_rd_d;

    logic [NUM_PORTS-1:0]   req_pend;
    logic                   win_found;
    logic [PW-1:0]          win_idx;
    int                     cand;

    // A port whose accept pulse is still on the wire is masked so a client that drops its
    // request on the edge after req_rdy is not granted the same command twice.
    assign req_pend = (req_wr | req_rd) & ~req_rdy_q;

    // Round-robin search: first pending port after last, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NP; k++) begin
            cand = (int'(last_q) + k) % NP;
            if (!win_found && req_pend[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    // Next-state and registered-output logic for the command sequencer.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant_q;
        ctl_wr_d      = ctl_wr_q;
        ctl_rd_d      = ctl_rd_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_data_wr_d = ctl_data_wr_q;
        req_rdy_d     = '0;
        req_val_d     = '0;
        req_data_rd_d = req_data_rd_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    last_d        = win_idx;
                    grant_d       = win_idx;
                    ctl_addr_d    = req_addr[int'(win_idx)*AW +: AW];
                    ctl_data_wr_d = req_data_wr[int'(win_idx)*8 +: 8];
                    // Write takes precedence when a port raises both strobes.
                    ctl_wr_d      = req_wr[win_idx];
                    ctl_rd_d      = ~req_wr[win_idx];
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                if (ctl_rdy) begin
                    ctl_wr_d           = 1'b0;
                    ctl_rd_d           = 1'b0;
                    req_rdy_d[grant_q] = 1'b1;
                    state_d            = ctl_rd_q ? StWaitRd : StIdle;
                end
            end
            StWaitRd: begin
                if (ctl_val) begin
                    req_data_rd_d      = ctl_data_rd;
                    req_val_d[grant_q] = 1'b1;
                    state_d            = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            last_q        <= PW'(NUM_PORTS - 1);
            grant_q       <= '0;
            ctl_wr_q      <= 1'b0;
            ctl_rd_q      <= 1'b0;
            ctl_addr_q    <= '0;
            ctl_data_wr_q <= '0;
            req_rdy_q     <= '0;
            req_val_q     <= '0;
            req_data_rd_q <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            ctl_wr_q      <= ctl_wr_d;
            ctl_rd_q      <= ctl_rd_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_data_wr_q <= ctl_data_wr_d;
            req_rdy_q     <= req_rdy_d;
            req_val_q     <= req_val_d;
            req_data_rd_q <= req_data_rd_d;
        end
    end

    assign req_rdy     = req_rdy_q;
    assign req_val     = req_val_q;
    assign req_data_rd = req_data_rd_q;
    assign ctl_wr      = ctl_wr_q;
    assign ctl_rd      = ctl_rd_q;
    assign ctl_addr    = ctl_addr_q;
    assign ctl_data_wr = ctl_data_wr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small behavioural controller model.
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int AD = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_wr, req_rd;
    logic [NP*AD-1:0]  req_addr;
    logic [NP*8-1:0]   req_data_wr;
    logic [NP-1:0]     req_rdy, req_val;
    logic [7:0]        req_data_rd;
    logic              ctl_wr, ctl_rd;
    logic [AD-1:0]     ctl_addr;
    logic [7:0]        ctl_data_wr;
    logic              ctl_rdy;
    logic              ctl_val = 1'b0;
    logic [7:0]        ctl_data_rd = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_DEPTH(AD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_wr     (req_wr),
        .req_rd     (req_rd),
        .req_addr   (req_addr),
        .req_data_wr(req_data_wr),
        .req_rdy    (req_rdy),
        .req_val    (req_val),
        .req_data_rd(req_data_rd),
        .ctl_wr     (ctl_wr),
        .ctl_rd     (ctl_rd),
        .ctl_addr   (ctl_addr),
        .ctl_data_wr(ctl_data_wr),
        .ctl_rdy    (ctl_rdy),
        .ctl_val    (ctl_val),
        .ctl_data_rd(ctl_data_rd)
    );

    always #5 clk = ~clk;

    // Controller model: byte memory on the low address byte, read data after rd_delay cycles.
    logic [7:0]  mem [256];
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;
    logic [7:0]  rd_a = 8'h00;
    int          rd_delay = 1;

    always @(posedge clk) begin
        ctl_val <= 1'b0;
        if (ctl_rdy && ctl_wr) mem[ctl_addr[7:0]] <= ctl_data_wr;
        if (ctl_rdy && ctl_rd) begin
            rd_pend <= 1'b1;
            rd_cnt  <= rd_delay;
            rd_a    <= ctl_addr[7:0];
        end else if (rd_pend) begin
            if (rd_cnt <= 1) begin
                ctl_val     <= 1'b1;
                ctl_data_rd <= mem[rd_a];
                rd_pend     <= 1'b0;
            end else begin
                rd_cnt <= rd_cnt - 1;
            end
        end
    end

    // Log accept and data pulses; flag any multi-port pulse.
    logic [NP-1:0] rdy_log [$];
    logic [NP-1:0] val_log [$];
    logic [7:0]    dat_log [$];
    logic          onehot_bad = 1'b0;

    always @(negedge clk) begin
        if (req_rdy != 0) rdy_log.push_back(req_rdy);
        if (req_val != 0) begin
            val_log.push_back(req_val);
            dat_log.push_back(req_data_rd);
        end
        if ($countones(req_rdy) > 1 || $countones(req_val) > 1) onehot_bad <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_port(input int p, input logic wr, input logic rd,
                            input logic [AD-1:0] a, input logic [7:0] d);
        req_wr[p]              = wr;
        req_rd[p]              = rd;
        req_addr[p*AD +: AD]   = a;
        req_data_wr[p*8 +: 8]  = d;
    endtask

    initial begin
        int n;
        int w;
        int early;

        rst = 1'b1;
        req_wr = '0;
        req_rd = '0;
        req_addr = '0;
        req_data_wr = '0;
        ctl_rdy = 1'b1;
        rd_delay = 1;
        step(3);
        chk("rst_strobes", {ctl_wr, ctl_rd, req_rdy, req_val}, 6'b0);
        chk("rst_addr", ctl_addr, 24'h0);
        chk("rst_wdata", ctl_data_wr, 8'h00);
        chk("rst_rdata", req_data_rd, 8'h00);
        rst = 1'b0;

        // Single write from port 0, controller stalls one cycle.
        ctl_rdy = 1'b0;
        set_port(0, 1'b1, 1'b0, 24'h123456, 8'hA5);
        step(1);
        chk("t1_cmd", {ctl_wr, ctl_rd}, 2'b10);
        chk("t1_addr", ctl_addr, 24'h123456);
        chk("t1_wdata", ctl_data_wr, 8'hA5);
        step(1);
        chk("t1_hold", {ctl_wr, ctl_rd, req_rdy}, 4'b1000);
        ctl_rdy = 1'b1;
        step(1);
        chk("t1_accept", {ctl_wr, ctl_rd, req_rdy, req_val}, 6'b000100);
        req_wr[0] = 1'b0;
        step(1);
        chk("t1_pulse_end", {req_rdy, req_val}, 4'b0000);

        // Port 1 writes then reads back through the model.
        set_port(1, 1'b1, 1'b0, 24'h000010, 8'h3C);
        step(1);
        chk("t2_wr_cmd", {ctl_wr, ctl_rd}, 2'b10);
        chk("t2_wr_addr", ctl_addr, 24'h000010);
        chk("t2_wr_data", ctl_data_wr, 8'h3C);
        step(1);
        chk("t2_wr_rdy", req_rdy, 2'b10);
        req_wr[1] = 1'b0;
        step(1);
        req_rd[1] = 1'b1;
        step(1);
        chk("t2_rd_cmd", {ctl_wr, ctl_rd}, 2'b01);
        chk("t2_rd_addr", ctl_addr, 24'h000010);
        step(1);
        chk("t2_rd_rdy", req_rdy, 2'b10);
        req_rd[1] = 1'b0;
        step(1);
        chk("t2_no_val_yet", req_val, 2'b00);
        step(1);
        chk("t2_val", {req_val, req_data_rd}, {2'b10, 8'h3C});
        step(1);
        chk("t2_val_hold", {req_val, req_data_rd}, {2'b00, 8'h3C});

        // Both ports read continuously: grants alternate starting at port 0.
        rdy_log.delete();
        val_log.delete();
        dat_log.delete();
        set_port(0, 1'b0, 1'b1, 24'h123456, 8'h00);
        set_port(1, 1'b0, 1'b1, 24'h000010, 8'h00);
        n = 0;
        for (int i = 0; i < 200 && n < 6; i++) begin
            step(1);
            if (req_rdy != 0) n++;
        end
        req_rd = '0;
        chk("t3_grants", n, 6);
        for (int i = 0; i < 50 && val_log.size() < 6; i++) step(1);
        chk("t3_vals", val_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_cmd%0d", i), {rdy_log[i], val_log[i], dat_log[i]},
                (i % 2 == 0) ? {2'b01, 2'b01, 8'hA5} : {2'b10, 2'b10, 8'h3C});
        end

        // Port 0 raises wr and rd together: write goes first, read after wr drops.
        set_port(0, 1'b1, 1'b1, 24'h000020, 8'h77);
        step(1);
        chk("t4_wr_first", {ctl_wr, ctl_rd}, 2'b10);
        chk("t4_wdata", ctl_data_wr, 8'h77);
        step(1);
        chk("t4_wr_rdy", req_rdy, 2'b01);
        req_wr[0] = 1'b0;
        w = 0;
        while (!ctl_rd && w < 20) begin
            step(1);
            w++;
        end
        chk("t4_rd_issued", {ctl_wr, ctl_rd}, 2'b01);
        chk("t4_rd_addr", ctl_addr, 24'h000020);
        step(1);
        chk("t4_rd_rdy", req_rdy, 2'b01);
        req_rd[0] = 1'b0;
        w = 0;
        while (req_val == 0 && w < 20) begin
            step(1);
            w++;
        end
        chk("t4_val", {req_val, req_data_rd}, {2'b01, 8'h77});

        // Slow read on port 0 blocks a write from port 1 until the data returns.
        rd_delay = 10;
        set_port(0, 1'b0, 1'b1, 24'h123456, 8'h00);
        step(1);
        chk("t5_rd_cmd", {ctl_wr, ctl_rd}, 2'b01);
        step(1);
        chk("t5_rd_rdy", req_rdy, 2'b01);
        req_rd[0] = 1'b0;
        set_port(1, 1'b1, 1'b0, 24'h000040, 8'h99);
        w = 0;
        early = 0;
        while (req_val == 0 && w < 40) begin
            step(1);
            w++;
            if (ctl_wr) early++;
        end
        chk("t5_val", {req_val, req_data_rd}, {2'b01, 8'hA5});
        chk("t5_latency", w, 11);
        chk("t5_blocked", early, 0);
        step(1);
        chk("t5_wr_cmd", {ctl_wr, ctl_addr, ctl_data_wr}, {1'b1, 24'h000040, 8'h99});
        step(1);
        chk("t5_wr_rdy", req_rdy, 2'b10);
        req_wr[1] = 1'b0;
        step(1);

        // Reset while waiting on read data.
        rd_delay = 5;
        set_port(0, 1'b0, 1'b1, 24'h123456, 8'h00);
        step(1);
        chk("t6_rd_cmd", {ctl_wr, ctl_rd}, 2'b01);
        step(1);
        chk("t6_rd_rdy", req_rdy, 2'b01);
        req_rd[0] = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_strobes", {ctl_wr, ctl_rd, req_rdy, req_val}, 6'b0);
        chk("t6_rst_addr", ctl_addr, 24'h0);
        chk("t6_rst_wdata", ctl_data_wr, 8'h00);
        chk("t6_rst_rdata", req_data_rd, 8'h00);
        rst = 1'b0;
        val_log.delete();
        step(8);
        chk("t6_no_val", val_log.size(), 0);
        set_port(0, 1'b1, 1'b0, 24'h000050, 8'h11);
        set_port(1, 1'b1, 1'b0, 24'h000060, 8'h22);
        step(1);
        chk("t6_p0_first", {ctl_wr, ctl_addr, ctl_data_wr}, {1'b1, 24'h000050, 8'h11});
        step(1);
        chk("t6_p0_rdy", req_rdy, 2'b01);
        req_wr[0] = 1'b0;
        w = 0;
        while (!ctl_wr && w < 20) begin
            step(1);
            w++;
        end
        chk("t6_p1_next", {ctl_wr, ctl_addr, ctl_data_wr}, {1'b1, 24'h000060, 8'h22});
        step(1);
        chk("t6_p1_rdy", req_rdy, 2'b10);
        req_wr[1] = 1'b0;
        step(2);

        chk("onehot_pulses", onehot_bad, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
